timer_seq_ctrl: RTL and testbench

//  Sequencer for an external N-bit my_bin_counter used as a down-counting interval timer.

---
 rtl/timer_seq_ctrl_pkg.sv | 17 +
 rtl/my_bin_counter.sv | 51 +++++
 rtl/timer_seq_ctrl.sv | 115 +++++++++++
 tb/tb_timer_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_ctrl_pkg.sv
// Shared types for the interval-timer sequencer.
// State encoding is fixed at 2 bits: IDLE=0, LOAD=1, RUN=2, DONE=3.
package timer_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // True for every state in which a run is in progress
   function automatic logic is_busy(input state_e s);
      return (s != S_IDLE);
   endfunction

endpackage

// File: rtl/my_bin_counter.sv
// Universal N-bit binary counter (the counter the sequencer drives).
// Priority: syn_clr > load > en; counts up or down according to up_i.
module my_bin_counter #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         syn_clr_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic         up_i,
   input  logic [N-1:0] d_i,
   output logic         max_tick_o,
   output logic         min_tick_o,
   output logic [N-1:0] q_o
);

   logic [N-1:0] q_q;
   logic [N-1:0] q_d;

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // Next count value
   always_comb begin
      q_d = q_q;
      if (syn_clr_i) begin
         q_d = '0;
      end else if (load_i) begin
         q_d = d_i;
      end else if (en_i && up_i) begin
         q_d = q_q + 1'b1;
      end else if (en_i) begin
         q_d = q_q - 1'b1;
      end
   end

   // Terminal-count flags and count output
   always_comb begin
      q_o        = q_q;
      max_tick_o = (q_q == '1);
      min_tick_o = (q_q == '0);
   end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Sequencer for an external down-counting my_bin_counter used as an
// interval timer: start -> load period -> count to zero -> done, with
// optional auto-reload and abort.
// Optional feature: define TIMER_SEQ_TOGGLE_EN to add toggle_o, a blink
// output that inverts once per completed run.
module timer_seq_ctrl
   import timer_seq_ctrl_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          ABORT_CLR = 1'b1
) (
   input  logic         sysclk,
   input  logic         reset_n,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic         repeat_i,
   input  logic [N-1:0] period_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         cnt_load_o,
   output logic         cnt_en_o,
   output logic         cnt_up_o,
   output logic         cnt_syn_clr_o,
   output logic [N-1:0] cnt_d_o,
   input  logic         cnt_min_tick_i
`ifdef TIMER_SEQ_TOGGLE_EN
   ,
   output logic         toggle_o
`endif
);

   state_e       state_q, state_d;
   logic [N-1:0] period_q, period_d;
   logic         clr_q, clr_d;

   // State register
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched period and registered clear request
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         period_q <= '0;
         clr_q    <= 1'b0;
      end else begin
         period_q <= period_d;
         clr_q    <= clr_d;
      end
   end

   // Next-state logic; abort overrides every transition out of a busy state
   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      clr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               state_d  = S_LOAD;
               period_d = period_i;
            end
         end
         S_LOAD: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_min_tick_i) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = repeat_i ? S_LOAD : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (is_busy(state_q) && abort_i) begin
         state_d = S_IDLE;
         clr_d   = ABORT_CLR;
      end
   end

   // Output decode; cnt_en_o alone looks at the counter's min_tick
   always_comb begin
      busy_o        = is_busy(state_q);
      done_o        = (state_q == S_DONE);
      cnt_load_o    = (state_q == S_LOAD);
      cnt_en_o      = (state_q == S_RUN) && !cnt_min_tick_i;
      cnt_up_o      = 1'b0;
      cnt_syn_clr_o = clr_q;
      cnt_d_o       = period_q;
   end

`ifdef TIMER_SEQ_TOGGLE_EN
   logic toggle_q;

   // Blink register: inverts after each DONE cycle
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q <= 1'b0;
      end else if (state_q == S_DONE) begin
         toggle_q <= ~toggle_q;
      end
   end

   assign toggle_o = toggle_q;
`endif

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Self-checking bench for timer_seq_ctrl driving a real my_bin_counter.
// Define TIMER_SEQ_TOGGLE_EN to also exercise toggle_o.
module tb_timer_seq_ctrl;

   localparam int unsigned N         = 8;
   localparam bit          ABORT_CLR = 1'b1;

   logic         sysclk   = 1'b0;
   logic         reset_n  = 1'b0;
   logic         start_i  = 1'b0;
   logic         abort_i  = 1'b0;
   logic         repeat_i = 1'b0;
   logic [N-1:0] period_i = '0;
   logic         busy_o, done_o, cnt_load_o, cnt_en_o, cnt_up_o, cnt_syn_clr_o;
   logic [N-1:0] cnt_d_o;
   logic         cnt_min_tick, cnt_max_tick;
   logic [N-1:0] cnt_q;
`ifdef TIMER_SEQ_TOGGLE_EN
   logic         toggle_o;
`endif

   always #5 sysclk = ~sysclk;

   timer_seq_ctrl #(.N(N), .ABORT_CLR(ABORT_CLR)) dut (
      .sysclk         (sysclk),
      .reset_n        (reset_n),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .repeat_i       (repeat_i),
      .period_i       (period_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .cnt_load_o     (cnt_load_o),
      .cnt_en_o       (cnt_en_o),
      .cnt_up_o       (cnt_up_o),
      .cnt_syn_clr_o  (cnt_syn_clr_o),
      .cnt_d_o        (cnt_d_o),
      .cnt_min_tick_i (cnt_min_tick)
`ifdef TIMER_SEQ_TOGGLE_EN
      ,
      .toggle_o       (toggle_o)
`endif
   );

   my_bin_counter #(.N(N)) u_cnt (
      .clk        (sysclk),
      .reset_n    (reset_n),
      .syn_clr_i  (cnt_syn_clr_o),
      .load_i     (cnt_load_o),
      .en_i       (cnt_en_o),
      .up_i       (cnt_up_o),
      .d_i        (cnt_d_o),
      .max_tick_o (cnt_max_tick),
      .min_tick_o (cnt_min_tick),
      .q_o        (cnt_q)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Timeline model: m_k counts cycles since a run was accepted
   // (1 = load cycle, 2..P+2 = counting, P+3 = done cycle).
   bit m_busy;
   int m_k;
   int m_P;
   bit m_clr;
   int m_q;
   bit m_tog;

   int dones_seen;
   int last_done_cyc;
   int en_cnt;
   int t0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_k    = 0;
      m_P    = 0;
      m_clr  = 1'b0;
      m_q    = 0;
      m_tog  = 1'b0;
   endtask

   // Check the current cycle, drive inputs for the next edge, advance the model
   task automatic step(input logic s, input logic a, input logic r, input logic [N-1:0] p);
      bit e_load, e_en, e_done;
      e_load = m_busy && (m_k == 1);
      e_en   = m_busy && (m_k >= 2) && (m_k <= m_P + 1);
      e_done = m_busy && (m_k == m_P + 3);

      chk("busy",    32'(busy_o),        32'(m_busy));
      chk("done",    32'(done_o),        32'(e_done));
      chk("load",    32'(cnt_load_o),    32'(e_load));
      chk("en",      32'(cnt_en_o),      32'(e_en));
      chk("syn_clr", 32'(cnt_syn_clr_o), 32'(m_clr));
      chk("d",       32'(cnt_d_o),       32'(m_P));
      chk("up",      32'(cnt_up_o),      32'(0));
      chk("q",       32'(cnt_q),         32'(m_q));
      chk("load_en_excl", 32'(cnt_load_o & cnt_en_o), 32'(0));
`ifdef TIMER_SEQ_TOGGLE_EN
      chk("toggle",  32'(toggle_o),      32'(m_tog));
`endif
      if (done_o === 1'b1) begin
         dones_seen++;
         last_done_cyc = cyc;
      end
      if (cnt_en_o === 1'b1) en_cnt++;

      start_i  = s;
      abort_i  = a;
      repeat_i = r;
      period_i = p;

      // counter behaviour for the coming edge
      if (m_clr)       m_q = 0;
      else if (e_load) m_q = m_P;
      else if (e_en)   m_q = m_q - 1;
      if (e_done) m_tog = ~m_tog;

      m_clr = 1'b0;
      if (!m_busy) begin
         if (s && !a) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_P    = int'(p);
         end
      end else if (a) begin
         m_busy = 1'b0;
         m_clr  = ABORT_CLR;
      end else if (m_k == m_P + 3) begin
         if (r) m_k = 1;
         else   m_busy = 1'b0;
      end else begin
         m_k++;
      end

      @(negedge sysclk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, N'($urandom));
   endtask

   task automatic start_run(input logic [N-1:0] p, input logic r);
      dones_seen = 0;
      en_cnt     = 0;
      t0         = cyc;
      step(1'b1, 1'b0, r, p);
   endtask

   initial begin
      model_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge sysclk);
      chk("rst_busy", 32'(busy_o), 32'(0));
      chk("rst_done", 32'(done_o), 32'(0));
      chk("rst_load", 32'(cnt_load_o), 32'(0));
      chk("rst_en",   32'(cnt_en_o), 32'(0));
      chk("rst_clr",  32'(cnt_syn_clr_o), 32'(0));
      chk("rst_d",    32'(cnt_d_o), 32'(0));
      reset_n = 1'b1;
      idle(2);

      // 1: P=10 one-shot
      start_run(8'h0A, 1'b0);
      idle(14);
      chk("t1_latency", 32'(last_done_cyc - t0), 32'(13));
      chk("t1_dones",   32'(dones_seen), 32'(1));
      chk("t1_en_cyc",  32'(en_cnt), 32'(10));

      // 2: P=0
      start_run(8'h00, 1'b0);
      idle(5);
      chk("t2_latency", 32'(last_done_cyc - t0), 32'(3));
      chk("t2_dones",   32'(dones_seen), 32'(1));

      // 3: P=3 periodic, period_i changed mid-run
      start_run(8'd3, 1'b1);
      step(1'b0, 1'b0, 1'b1, 8'd3);
      for (int i = 0; i < 22; i++) step($urandom_range(0, 1), 1'b0, 1'b1, 8'd9);
      step(1'b0, 1'b0, 1'b0, 8'd9);
      idle(4);
      chk("t3_dones",   32'(dones_seen), 32'(4));
      chk("t3_last",    32'(last_done_cyc - t0), 32'(24));

      // 4: P=20 abort at RUN cycle 5; then start+abort in IDLE
      start_run(8'd20, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'd20);
      step(1'b0, 1'b1, 1'b0, 8'd20);
      chk("t4_syn_clr", 32'(cnt_syn_clr_o), 32'(ABORT_CLR));
      chk("t4_busy",    32'(busy_o), 32'(0));
      idle(4);
      chk("t4_q",       32'(cnt_q), 32'(0));
      chk("t4_no_done", 32'(dones_seen), 32'(0));
      step(1'b1, 1'b1, 1'b0, 8'd7);
      idle(2);
      chk("t4_start_abort_idle", 32'(busy_o), 32'(0));

      // 5: async reset mid-run, then a normal restart
      start_run(8'd30, 1'b0);
      idle(9);
      #3 reset_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy_o), 32'(0));
      chk("t5_load", 32'(cnt_load_o), 32'(0));
      chk("t5_en",   32'(cnt_en_o), 32'(0));
      chk("t5_done", 32'(done_o), 32'(0));
      chk("t5_d",    32'(cnt_d_o), 32'(0));
      chk("t5_q",    32'(cnt_q), 32'(0));
      model_reset();
      @(negedge sysclk);
      cyc++;
      reset_n = 1'b1;
      idle(2);
      start_run(8'd5, 1'b0);
      idle(10);
      chk("t5_restart_latency", 32'(last_done_cyc - t0), 32'(8));

      // P = 2^N-1
      start_run(8'hFF, 1'b0);
      idle(261);
      chk("pmax_latency", 32'(last_done_cyc - t0), 32'(258));
      chk("pmax_en_cyc",  32'(en_cnt), 32'(255));

`ifdef TIMER_SEQ_TOGGLE_EN
      // 6: P=1 periodic blink
      start_run(8'd1, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'd1);
      step(1'b0, 1'b1, 1'b0, 8'd1);
      idle(2);
      chk("t6_dones", 32'(dones_seen), 32'(4));
`endif

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [N-1:0] p;
         p = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'($urandom_range(0, 12));
         step(($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0),
              1'($urandom_range(0, 1)), p);
      end
      step(1'b0, 1'b1, 1'b0, '0);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
